// File: rtl/lcd_write_ctrl.sv
// lcd_write_ctrl
//   Pops bytes from a show-ahead character FIFO and writes them to an
//   HD44780-compatible LCD over an 8-bit parallel bus, generating RS/E
//   setup, enable pulse and execution wait timing. Byte 0xFE escapes the
//   following byte so it is sent as a command (RS=0); all other bytes are
//   sent as character data (RS=1).
//
//   Optional feature macro: LCD_INIT_SEQ_EN
//     defined   - after reset, wait POWERUP_CYCLES, then send the init commands
//                 0x38, 0x0C, 0x01, 0x06 before serving the FIFO.
//     undefined - reset enters IDLE directly; software sends its own init
//                 commands through 0xFE escapes.
//
// Ports
//   clock          system clock
//   reset_n        asynchronous active-low reset
//   fifo_out       FIFO head byte, valid whenever fifo_empty=0
//   fifo_empty     FIFO holds no data
//   fifo_out_read  one-cycle pop strobe (combinational)
//   lcd_data       LCD DB7..DB0
//   lcd_rs         0=command, 1=data
//   lcd_rw         tied 0 (write only)
//   lcd_e          LCD enable strobe
//   busy           high in every state except IDLE

module lcd_write_ctrl #(
    parameter int E_PULSE_CYCLES = 25,
    parameter int EXEC_CYCLES    = 2000,
    parameter int CLEAR_CYCLES   = 82000,
    parameter int POWERUP_CYCLES = 2000000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] fifo_out,
    input  logic       fifo_empty,
    output logic       fifo_out_read,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic       busy
);

    localparam int MAX_AB  = (E_PULSE_CYCLES > EXEC_CYCLES) ? E_PULSE_CYCLES : EXEC_CYCLES;
    localparam int MAX_CD  = (CLEAR_CYCLES > POWERUP_CYCLES) ? CLEAR_CYCLES : POWERUP_CYCLES;
    localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW      = $clog2(MAX_CYC) + 1;

    localparam logic [7:0] ESC_BYTE = 8'hFE;

`ifdef LCD_INIT_SEQ_EN
    typedef enum logic [2:0] {
        POWER_WAIT,
        INIT,
        IDLE,
        SETUP,
        PULSE,
        WAIT
    } state_t;

    localparam state_t        RESET_STATE = POWER_WAIT;
    localparam logic [CW-1:0] RESET_COUNT = CW'(POWERUP_CYCLES - 1);

    logic [1:0] init_idx;
    logic       init_done;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    init_cmd = 8'h38;   // 8-bit bus, 2 lines, 5x8 font
            2'd1:    init_cmd = 8'h0C;   // display on, cursor off
            2'd2:    init_cmd = 8'h01;   // clear display
            default: init_cmd = 8'h06;   // entry mode: increment, no shift
        endcase
    endfunction
`else
    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        PULSE,
        WAIT
    } state_t;

    localparam state_t        RESET_STATE = IDLE;
    localparam logic [CW-1:0] RESET_COUNT = '0;
`endif

    state_t        state;
    logic [CW-1:0] count;
    logic          esc_pending;
    logic          is_clear;

    // Pop only from IDLE with data present; reset_n gating keeps the strobe
    // low for the whole reset interval even though it is combinational.
    assign fifo_out_read = reset_n && (state == IDLE) && !fifo_empty;

    assign busy   = (state != IDLE);
    assign lcd_rw = 1'b0;

    // Clear display / return home need the long execution wait.
    assign is_clear = !lcd_rs && ((lcd_data == 8'h01) || (lcd_data == 8'h02));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= RESET_STATE;
            count       <= RESET_COUNT;
            lcd_data    <= '0;
            lcd_rs      <= 1'b0;
            lcd_e       <= 1'b0;
            esc_pending <= 1'b0;
`ifdef LCD_INIT_SEQ_EN
            init_idx    <= '0;
            init_done   <= 1'b0;
`endif
        end else begin
            case (state)
`ifdef LCD_INIT_SEQ_EN
                POWER_WAIT: begin
                    if (count == '0) begin
                        state <= INIT;
                    end else begin
                        count <= count - 1'b1;
                    end
                end

                INIT: begin
                    lcd_data <= init_cmd(init_idx);
                    lcd_rs   <= 1'b0;
                    state    <= SETUP;
                end
`endif
                IDLE: begin
                    if (fifo_out_read) begin
                        if (fifo_out == ESC_BYTE && !esc_pending) begin
                            esc_pending <= 1'b1;
                        end else begin
                            lcd_data    <= fifo_out;
                            lcd_rs      <= ~esc_pending;
                            esc_pending <= 1'b0;
                            state       <= SETUP;
                        end
                    end
                end

                SETUP: begin
                    lcd_e <= 1'b1;
                    count <= CW'(E_PULSE_CYCLES - 1);
                    state <= PULSE;
                end

                PULSE: begin
                    if (count == '0) begin
                        lcd_e <= 1'b0;
                        count <= is_clear ? CW'(CLEAR_CYCLES) : CW'(EXEC_CYCLES);
                        state <= WAIT;
                    end else begin
                        count <= count - 1'b1;
                    end
                end

                // Counts down to zero inclusive, so the bus stays idle for the
                // full execution time plus one turnaround cycle.
                WAIT: begin
                    if (count == '0) begin
`ifdef LCD_INIT_SEQ_EN
                        if (!init_done) begin
                            if (init_idx == 2'd3) begin
                                init_done <= 1'b1;
                                state     <= IDLE;
                            end else begin
                                init_idx <= init_idx + 2'd1;
                                state    <= INIT;
                            end
                        end else begin
                            state <= IDLE;
                        end
`else
                        state <= IDLE;
`endif
                    end else begin
                        count <= count - 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
